// File: rtl/ranc_packet_pkg.sv
// Shared packet layout and output-stage encoding for the spike output path.
package ranc_packet_pkg;

  // Field widths of a spike packet {dx, dy, axon, tick}.
  localparam int DX_W     = 9;
  localparam int DY_W     = 9;
  localparam int AXON_W   = 8;
  localparam int TICK_W   = 4;
  localparam int PACKET_W = DX_W + DY_W + AXON_W + TICK_W;

  // Bit offsets of each field (LSB position).
  localparam int TICK_LSB = 0;
  localparam int AXON_LSB = TICK_LSB + TICK_W;
  localparam int DY_LSB   = AXON_LSB + AXON_W;
  localparam int DX_LSB   = DY_LSB + DY_W;

  typedef struct packed {
    logic [DX_W-1:0]   dx;
    logic [DY_W-1:0]   dy;
    logic [AXON_W-1:0] axon;
    logic [TICK_W-1:0] tick;
  } spike_packet_t;

  // Output register state: empty or holding a packet for the router.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/spike_fifo_mem.sv
// Register-array storage for the spike FIFO: synchronous write, asynchronous read.
module spike_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the array is deliberately not reset; pointers define which entries are
  // valid, so clearing the storage would only add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spike_packet_out_buffer.sv
// Buffers spike packets from the neuron grid and hands them to the router
// through a registered output stage, with grid backpressure and drop status.
module spike_packet_out_buffer
  import ranc_packet_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int FULL_MARGIN  = 2,
  parameter int PACKET_WIDTH = PACKET_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PACKET_WIDTH-1:0]  packet_in,
  input  logic                     packet_in_valid,
  output logic                     local_buffers_full,
  output logic [PACKET_WIDTH-1:0]  packet_out,
  output logic                     packet_out_valid,
  input  logic                     packet_out_ready,
  output logic                     buffer_empty,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   occupancy,
  input  logic                     clear_status
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] MARGIN_C = OCC_W'(FULL_MARGIN);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]             wptr;
  logic [AW:0]             rptr;
  logic [PACKET_WIDTH-1:0] rd_data;

  out_state_e              state;
  out_state_e              state_next;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    out_free;
  logic                    pop;
  logic                    bypass;
  logic                    fifo_wr;
  logic                    drop;
  logic                    load;
  logic [PACKET_WIDTH-1:0] load_data;

  assign occupancy        = wptr - rptr;
  assign fifo_empty       = (occupancy == '0);
  assign fifo_full        = (occupancy == DEPTH_C);
  assign packet_out_valid = (state == OUT_FULL);
  assign buffer_empty     = fifo_empty && !packet_out_valid;

  spike_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (fifo_wr),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (packet_in),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (rd_data)
  );

  // Output-stage state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= OUT_EMPTY;
    else          state <= state_next;
  end

  // Next-state and datapath control: reload from FIFO, bypass, write or drop.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    out_free   = (state == OUT_EMPTY) || packet_out_ready;
    pop        = 1'b0;
    bypass     = 1'b0;
    fifo_wr    = 1'b0;
    drop       = 1'b0;
    load       = 1'b0;
    load_data  = rd_data;

    if (out_free) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        load       = 1'b1;
        load_data  = rd_data;
        state_next = OUT_FULL;
      end else if (packet_in_valid) begin
        bypass     = 1'b1;
        load       = 1'b1;
        load_data  = packet_in;
        state_next = OUT_FULL;
      end else begin
        state_next = OUT_EMPTY;
      end
    end

    // A same-cycle pop frees a slot, so a write into a full FIFO still lands.
    if (packet_in_valid && !bypass) begin
      if (!fifo_full || pop) fifo_wr = 1'b1;
      else                   drop    = 1'b1;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (fifo_wr) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // Output register: holds steady until the router accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  packet_out <= '0;
    else if (load) packet_out <= load_data;
  end

  // Registered backpressure, sized to cover the grid's stall latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) local_buffers_full <= 1'b0;
    else          local_buffers_full <= ((DEPTH_C - occupancy) <= MARGIN_C);
  end

  // Drop status: a drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_status)               drop_count <= 8'd1;
      else if (drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
    end else if (clear_status) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
